gemm_tile_engine: RTL and testbench

- Parametrised successor of the single-tile GeMM top. It computes C[M×N] = A[M×K]·B[K×N] with an MT×NT array of KT-wide dot-product PEs.
- It iterates over tiles: M/MT × N/NT output tiles, each accumulated over K/KT beats.
- Generalised beyond the single-tile top: configurable SRAM read latency, selectable B layout, C write backpressure through an output FIFO, and size checking.
- Sits between the tile SRAMs A, B and C and the host start/done interface.

---
 rtl/gemm_tile_pkg.sv | 32 +++
 rtl/gemm_out_fifo.sv | 66 ++++++
 rtl/gemm_tile_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_pkg.sv
// Shared types for the tiled GeMM engine: FSM states, read-pipe tag,
// and the start-time size legality rule.
package gemm_tile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int unsigned CAddrW = 10;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [CAddrW-1:0] c_addr;
    } rd_tag_t;

    function automatic logic size_legal(
        input int unsigned m,
        input int unsigned k,
        input int unsigned n,
        input int unsigned mt,
        input int unsigned kt,
        input int unsigned nt
    );
        return (m != 0) && (k != 0) && (n != 0) &&
               (m % mt == 0) && (k % kt == 0) && (n % nt == 0);
    endfunction

endpackage

// File: rtl/gemm_out_fifo.sv
// Small circular FIFO holding finished output tiles until the C SRAM
// accepts them.
module gemm_out_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == CntW'(Depth);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = nxt(wr_q);
        end
        if (do_pop) begin
            rd_d = nxt(rd_q);
        end
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gemm_tile_engine.sv
// Tiled GeMM engine: walks M/MT x N/NT output tiles, accumulating each
// over K/KT beats in an MT x NT array of KT-wide dot-product PEs.
module gemm_tile_engine
    import gemm_tile_pkg::*;
#(
    parameter int unsigned InDataWidth  = 8,
    parameter int unsigned OutDataWidth = 32,
    parameter int unsigned MT           = 4,
    parameter int unsigned NT           = 4,
    parameter int unsigned KT           = 4,
    parameter int unsigned SizeWidth    = 8,
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned AddrWidthC   = 10,
    parameter int unsigned RdLatency    = 1,
    parameter int unsigned OutFifoDepth = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic [SizeWidth-1:0]                M_size_i,
    input  logic [SizeWidth-1:0]                K_size_i,
    input  logic [SizeWidth-1:0]                N_size_i,
    input  logic                                b_trans_i,
    output logic                                sram_a_re_o,
    output logic [AddrWidth-1:0]                sram_a_addr_o,
    input  logic [InDataWidth*MT*KT-1:0]        sram_a_rdata_i,
    output logic                                sram_b_re_o,
    output logic [AddrWidth-1:0]                sram_b_addr_o,
    input  logic [InDataWidth*KT*NT-1:0]        sram_b_rdata_i,
    output logic                                sram_c_we_o,
    input  logic                                sram_c_ready_i,
    output logic [AddrWidthC-1:0]               sram_c_addr_o,
    output logic [OutDataWidth*MT*NT-1:0]       sram_c_wdata_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int unsigned RowW = KT * InDataWidth;
    localparam int unsigned CW   = OutDataWidth * MT * NT;
    localparam int unsigned OW   = $clog2(OutFifoDepth + 1);
    localparam int unsigned FW   = CW + AddrWidthC;

    state_e               state_q, state_d;
    logic [SizeWidth-1:0] mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
    logic [SizeWidth-1:0] mcnt_q, mcnt_d, ncnt_q, ncnt_d;
    logic [SizeWidth-1:0] kcnt_q, kcnt_d;
    logic                 btrans_q, btrans_d, err_q, err_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 pvld_q [RdLatency];
    logic                 pvld_d [RdLatency];
    rd_tag_t              ptag_q [RdLatency];
    rd_tag_t              ptag_d [RdLatency];

    logic                  issue, stall, kt_last, nt_last, last_beat;
    logic                  inc, pop, push, pipe_busy;
    logic                  fifo_full, fifo_empty;
    logic [AddrWidthC-1:0] c_addr;
    logic [AddrWidth-1:0]  a_addr, b_addr;
    rd_tag_t               tag, ret_tag;
    logic                  ret_vld;
    logic [CW-1:0]         acc_new;
    logic [FW-1:0]         fifo_head;

    assign kt_last   = kt_q == kcnt_q - 1'b1;
    assign nt_last   = nt_q == ncnt_q - 1'b1;
    assign last_beat = kt_last && nt_last && (mt_q == mcnt_q - 1'b1);
    // Credits are only checked when a new tile would start.
    assign stall     = (kt_q == '0) && (outst_q == OW'(OutFifoDepth));
    assign issue     = (state_q == RUN) && !stall;
    assign inc       = issue && kt_last;
    assign pop       = !fifo_empty && sram_c_ready_i;

    assign c_addr = AddrWidthC'(mt_q) * AddrWidthC'(ncnt_q)
                  + AddrWidthC'(nt_q);
    assign a_addr = AddrWidth'(mt_q) * AddrWidth'(kcnt_q)
                  + AddrWidth'(kt_q);
    assign b_addr = btrans_q
        ? AddrWidth'(nt_q) * AddrWidth'(kcnt_q) + AddrWidth'(kt_q)
        : AddrWidth'(kt_q) * AddrWidth'(ncnt_q) + AddrWidth'(nt_q);

    always_comb begin
        tag        = '0;
        tag.first  = kt_q == '0;
        tag.last   = kt_last;
        tag.c_addr = CAddrW'(c_addr);
    end

    assign ret_vld = pvld_q[RdLatency-1];
    assign ret_tag = ptag_q[RdLatency-1];
    assign push    = ret_vld && ret_tag.last && !fifo_full;

    assign sram_a_re_o    = issue;
    assign sram_b_re_o    = issue;
    assign sram_a_addr_o  = issue ? a_addr : '0;
    assign sram_b_addr_o  = issue ? b_addr : '0;
    assign sram_c_we_o    = !fifo_empty;
    assign sram_c_addr_o  = fifo_head[AddrWidthC-1:0];
    assign sram_c_wdata_o = fifo_head[FW-1:AddrWidthC];
    assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
    assign done_o         = state_q == DONE;
    assign err_o          = err_q;

    always_comb begin
        pvld_d[0] = issue;
        ptag_d[0] = tag;
        for (int i = 1; i < RdLatency; i++) begin
            pvld_d[i] = pvld_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end
        pipe_busy = 1'b0;
        for (int i = 0; i < RdLatency; i++) begin
            pipe_busy = pipe_busy | pvld_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        mt_d     = mt_q;
        nt_d     = nt_q;
        kt_d     = kt_q;
        mcnt_d   = mcnt_q;
        ncnt_d   = ncnt_q;
        kcnt_d   = kcnt_q;
        btrans_d = btrans_q;
        err_d    = 1'b0;
        outst_d  = outst_q;
        if (inc && !pop) begin
            outst_d = outst_q + 1'b1;
        end else if (!inc && pop) begin
            outst_d = outst_q - 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (size_legal(32'(M_size_i), 32'(K_size_i),
                                   32'(N_size_i), MT, KT, NT)) begin
                        state_d  = RUN;
                        mt_d     = '0;
                        nt_d     = '0;
                        kt_d     = '0;
                        mcnt_d   = SizeWidth'(M_size_i / MT);
                        kcnt_d   = SizeWidth'(K_size_i / KT);
                        ncnt_d   = SizeWidth'(N_size_i / NT);
                        btrans_d = b_trans_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (kt_last) begin
                        kt_d = '0;
                        if (nt_last) begin
                            nt_d = '0;
                            mt_d = mt_q + 1'b1;
                        end else begin
                            nt_d = nt_q + 1'b1;
                        end
                    end else begin
                        kt_d = kt_q + 1'b1;
                    end
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_busy && fifo_empty && outst_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mt_q     <= '0;
            nt_q     <= '0;
            kt_q     <= '0;
            mcnt_q   <= '0;
            ncnt_q   <= '0;
            kcnt_q   <= '0;
            btrans_q <= 1'b0;
            err_q    <= 1'b0;
            outst_q  <= '0;
            for (int i = 0; i < RdLatency; i++) begin
                pvld_q[i] <= 1'b0;
                ptag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            nt_q     <= nt_d;
            kt_q     <= kt_d;
            mcnt_q   <= mcnt_d;
            ncnt_q   <= ncnt_d;
            kcnt_q   <= kcnt_d;
            btrans_q <= btrans_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
            pvld_q   <= pvld_d;
            ptag_q   <= ptag_d;
        end
    end

    for (genvar m = 0; m < MT; m++) begin : g_row
        for (genvar n = 0; n < NT; n++) begin : g_col
            logic signed [OutDataWidth-1:0]  dot, acc_q, acc_d;
            logic signed [2*InDataWidth-1:0] prod;

            always_comb begin
                dot  = '0;
                prod = '0;
                for (int k = 0; k < KT; k++) begin
                    prod = $signed(sram_a_rdata_i[(MT-1-m)*RowW
                               + (KT-1-k)*InDataWidth +: InDataWidth])
                         * $signed(sram_b_rdata_i[(NT-1-n)*RowW
                               + (KT-1-k)*InDataWidth +: InDataWidth]);
                    dot  = dot + OutDataWidth'(prod);
                end
            end

            always_comb begin
                acc_d = acc_q;
                if (ret_vld) begin
                    acc_d = ret_tag.first ? dot : acc_q + dot;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            assign acc_new[(m*NT+n)*OutDataWidth +: OutDataWidth] = acc_d;
        end
    end

    gemm_out_fifo #(
        .Width (FW),
        .Depth (OutFifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({acc_new, AddrWidthC'(ret_tag.c_addr)}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Bench for gemm_tile_engine: two instances (read latency 1 and 3) share
// stimulus; results are checked against a full-matrix reference product.
module tb_gemm_tile_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] m_sz = '0, k_sz = '0, n_sz = '0;
    logic bt = 1'b0;
    logic ready = 1'b1;

    logic         a_re [2];
    logic [15:0]  a_addr [2];
    logic [127:0] a_rd [2];
    logic         b_re [2];
    logic [15:0]  b_addr [2];
    logic [127:0] b_rd [2];
    logic         c_we [2];
    logic [9:0]   c_addr [2];
    logic [511:0] c_wd [2];
    logic         busy [2];
    logic         done [2];
    logic         err [2];

    always #5 clk = ~clk;

    gemm_tile_engine #(.RdLatency(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
        .b_trans_i(bt),
        .sram_a_re_o(a_re[0]), .sram_a_addr_o(a_addr[0]),
        .sram_a_rdata_i(a_rd[0]),
        .sram_b_re_o(b_re[0]), .sram_b_addr_o(b_addr[0]),
        .sram_b_rdata_i(b_rd[0]),
        .sram_c_we_o(c_we[0]), .sram_c_ready_i(ready),
        .sram_c_addr_o(c_addr[0]), .sram_c_wdata_o(c_wd[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
    );

    gemm_tile_engine #(.RdLatency(3)) u_lat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
        .b_trans_i(bt),
        .sram_a_re_o(a_re[1]), .sram_a_addr_o(a_addr[1]),
        .sram_a_rdata_i(a_rd[1]),
        .sram_b_re_o(b_re[1]), .sram_b_addr_o(b_addr[1]),
        .sram_b_rdata_i(b_rd[1]),
        .sram_c_we_o(c_we[1]), .sram_c_ready_i(ready),
        .sram_c_addr_o(c_addr[1]), .sram_c_wdata_o(c_wd[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
    );

    logic [127:0] mem_a [64];
    logic [127:0] mem_b [64];
    logic [127:0] a_p1, a_p2, b_p1, b_p2;

    always @(posedge clk) begin
        a_rd[0] <= mem_a[a_addr[0][5:0]];
        b_rd[0] <= mem_b[b_addr[0][5:0]];
        a_p1    <= mem_a[a_addr[1][5:0]];
        b_p1    <= mem_b[b_addr[1][5:0]];
        a_p2    <= a_p1;
        b_p2    <= b_p1;
        a_rd[1] <= a_p2;
        b_rd[1] <= b_p2;
    end

    typedef struct packed {
        logic [9:0]   addr;
        logic [511:0] data;
    } wr_t;

    wr_t got0[$];
    wr_t got1[$];
    int  done_cnt [2] = '{0, 0};
    int  err_cnt [2]  = '{0, 0};
    int  re_cnt [2]   = '{0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            if (c_we[0] && ready) got0.push_back({c_addr[0], c_wd[0]});
            if (c_we[1] && ready) got1.push_back({c_addr[1], c_wd[1]});
            for (int d = 0; d < 2; d++) begin
                if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
                if (err[d])  err_cnt[d]  <= err_cnt[d] + 1;
                if (a_re[d]) re_cnt[d]   <= re_cnt[d] + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference model: whole matrices, plain integer product.
    int A [16][16];
    int B [16][16];
    int C [16][16];
    logic [511:0] exp_tile [16];

    task automatic gen(input int pat, input int m, input int k, input int n);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                case (pat)
                    1: begin
                        A[i][j] = (i == j) ? 1 : 0;
                        B[i][j] = int'(byte'($urandom()));
                    end
                    2: begin
                        A[i][j] = -128;
                        B[i][j] = -128;
                    end
                    default: begin
                        A[i][j] = int'(byte'($urandom()));
                        B[i][j] = int'(byte'($urandom()));
                    end
                endcase
            end
        end
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                C[i][j] = 0;
                for (int x = 0; x < k; x++) C[i][j] += A[i][x] * B[x][j];
            end
        end
    endtask

    task automatic load(input int m, input int k, input int n,
                        input logic trans);
        int mt_n, kt_n, nt_n;
        logic [127:0] v;
        logic [511:0] e;
        mt_n = m / 4;
        kt_n = k / 4;
        nt_n = n / 4;
        for (int ti = 0; ti < mt_n; ti++) begin
            for (int tk = 0; tk < kt_n; tk++) begin
                v = '0;
                for (int r = 0; r < 4; r++)
                    for (int x = 0; x < 4; x++)
                        v[(3-r)*32 + (3-x)*8 +: 8] = 8'(A[ti*4+r][tk*4+x]);
                mem_a[ti*kt_n+tk] = v;
            end
        end
        for (int tk = 0; tk < kt_n; tk++) begin
            for (int tj = 0; tj < nt_n; tj++) begin
                v = '0;
                for (int c = 0; c < 4; c++)
                    for (int x = 0; x < 4; x++)
                        v[(3-c)*32 + (3-x)*8 +: 8] = 8'(B[tk*4+x][tj*4+c]);
                if (trans) mem_b[tj*kt_n+tk] = v;
                else       mem_b[tk*nt_n+tj] = v;
            end
        end
        for (int ti = 0; ti < mt_n; ti++) begin
            for (int tj = 0; tj < nt_n; tj++) begin
                e = '0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        e[(r*4+c)*32 +: 32] = 32'(C[ti*4+r][tj*4+c]);
                exp_tile[ti*nt_n+tj] = e;
            end
        end
    endtask

    int base_g [2];
    int base_d [2];
    int base_e [2];
    int base_r [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        base_g[0] = got0.size();
        base_g[1] = got1.size();
        for (int d = 0; d < 2; d++) begin
            base_d[d] = done_cnt[d];
            base_e[d] = err_cnt[d];
            base_r[d] = re_cnt[d];
        end
    endtask

    task automatic start_op(input int m, input int k, input int n,
                            input logic trans);
        tick();
        snap();
        m_sz  = 8'(m);
        k_sz  = 8'(k);
        n_sz  = 8'(n);
        bt    = trans;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_op(input string nm, input int exp_wr,
                             input logic chk_el, input int el);
        int cyc;
        int nw;
        wr_t w;
        logic [511:0] rep;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (done_cnt[0] > base_d[0] && done_cnt[1] > base_d[1]) break;
        end
        repeat (2) @(negedge clk);
        chk($sformatf("%s timeout", nm), cyc < 3000, 1);
        for (int c = 0; c < 16; c++) rep[c*32 +: 32] = 32'(el);
        for (int d = 0; d < 2; d++) begin
            nw = (d == 0) ? got0.size() - base_g[0] : got1.size() - base_g[1];
            chk($sformatf("%s d%0d nwrites", nm, d), nw, exp_wr);
            for (int i = 0; i < nw && i < exp_wr; i++) begin
                if (d == 0) w = got0[base_g[0]+i];
                else        w = got1[base_g[1]+i];
                chk($sformatf("%s d%0d addr%0d", nm, d, i), w.addr, i);
                chk($sformatf("%s d%0d data%0d", nm, d, i), w.data,
                    exp_tile[i]);
                if (chk_el)
                    chk($sformatf("%s d%0d bound%0d", nm, d, i), w.data, rep);
            end
            chk($sformatf("%s d%0d done", nm, d),
                done_cnt[d] - base_d[d], 1);
            chk($sformatf("%s d%0d err", nm, d), err_cnt[d] - base_e[d], 0);
            chk($sformatf("%s d%0d busy", nm, d), busy[d], 0);
        end
    endtask

    task automatic finish_illegal(input string nm);
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d err", nm, d), err_cnt[d] - base_e[d], 1);
            chk($sformatf("%s d%0d reads", nm, d), re_cnt[d] - base_r[d], 0);
            chk($sformatf("%s d%0d done", nm, d),
                done_cnt[d] - base_d[d], 0);
            chk($sformatf("%s d%0d busy", nm, d), busy[d], 0);
        end
    endtask

    typedef struct {
        int   m, k, n;
        logic trans;
        int   pat;
        logic bad;
        int   nwr;
        logic chk_el;
        int   el;
    } vec_t;

    vec_t tbl [9];

    initial begin
        vec_t v;
        int lat0, lat1, rc, nbp;
        logic have;
        logic [522:0] hold, now;

        tbl[0] = '{4, 4, 4, 1'b0, 1, 1'b0, 1, 1'b0, 0};
        tbl[1] = '{8, 16, 8, 1'b0, 0, 1'b0, 4, 1'b0, 0};
        tbl[2] = '{8, 16, 8, 1'b1, 3, 1'b0, 4, 1'b0, 0};
        tbl[3] = '{4, 16, 4, 1'b0, 2, 1'b0, 1, 1'b1, 262144};
        tbl[4] = '{6, 4, 4, 1'b0, 0, 1'b1, 0, 1'b0, 0};
        tbl[5] = '{0, 4, 4, 1'b0, 0, 1'b1, 0, 1'b0, 0};
        tbl[6] = '{4, 4, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
        tbl[7] = '{4, 6, 4, 1'b0, 0, 1'b1, 0, 1'b0, 0};
        tbl[8] = '{12, 4, 8, 1'b1, 0, 1'b0, 6, 1'b0, 0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ctl d%0d", d),
                {a_re[d], a_addr[d], b_re[d], b_addr[d], c_we[d],
                 c_addr[d], busy[d], done[d], err[d]}, 0);
            chk($sformatf("reset wdata d%0d", d), c_wd[d], 0);
        end
        tick();
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++) begin
            v = tbl[t];
            if (v.pat != 3) gen(v.pat, v.m, v.k, v.n);
            if (!v.bad) load(v.m, v.k, v.n, v.trans);
            start_op(v.m, v.k, v.n, v.trans);
            if (v.bad) finish_illegal($sformatf("vec%0d", t));
            else finish_op($sformatf("vec%0d", t), v.nwr, v.chk_el, v.el);
        end

        // Backpressure: C ready dropped for 20 cycles mid-run.
        gen(0, 16, 4, 16);
        load(16, 4, 16, 1'b0);
        start_op(16, 4, 16, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (got0.size() >= base_g[0] + 3) break;
            tick();
        end
        ready = 1'b0;
        rc    = re_cnt[0];
        have  = 1'b0;
        hold  = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            now = {c_we[0], c_addr[0], c_wd[0]};
            if (have) chk($sformatf("bp hold%0d", i), now, hold);
            else if (c_we[0]) begin
                have = 1'b1;
                hold = now;
            end
        end
        nbp = re_cnt[0] - rc;
        chk("bp issued<=2", nbp <= 2, 1);
        chk("bp stalled", a_re[0], 0);
        chk("bp busy", busy[0], 1);
        ready = 1'b1;
        finish_op("bp", 16, 1'b0, 0);

        // First-write latency: Kt=2, read latency 1 and 3.
        gen(0, 4, 8, 4);
        load(4, 8, 4, 1'b0);
        tick();
        snap();
        m_sz  = 8'd4;
        k_sz  = 8'd8;
        n_sz  = 8'd4;
        bt    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat0 = -1;
        lat1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (lat0 < 0 && c_we[0]) lat0 = i;
            if (lat1 < 0 && c_we[1]) lat1 = i;
        end
        chk("latency L1", lat0, 3);
        chk("latency L3", lat1, 5);
        finish_op("lat", 1, 1'b0, 0);

        // Reset mid-run, then a clean restart.
        gen(0, 16, 16, 16);
        load(16, 16, 16, 1'b0);
        start_op(16, 16, 16, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst ctl d%0d", d),
                {a_re[d], a_addr[d], b_re[d], b_addr[d], c_we[d],
                 c_addr[d], busy[d], done[d], err[d]}, 0);
            chk($sformatf("midrst wdata d%0d", d), c_wd[d], 0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        gen(0, 8, 8, 8);
        load(8, 8, 8, 1'b1);
        start_op(8, 8, 8, 1'b1);
        finish_op("restart", 4, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
